// File: rtl/fb_write_buffer.sv
// Posted-write FIFO between the CPU frame-buffer store port and the frame-buffer RAM,
// draining only on display grant. Optional store coalescing: FB_WRITE_COALESCE_EN.
module fb_write_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_fb_en,
  input  logic                     cpu_mem_wen,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic                     cpu_stall_req,
  input  logic                     flush_req,
  output logic                     flush_done,
  input  logic                     fb_grant,
  output logic                     fb_wen,
  output logic [ADDR_W-1:0]        fb_addr,
  output logic [DATA_W-1:0]        fb_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT1 = CW'(1);
  localparam logic [AW-1:0] PTR1 = AW'(1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ACTIVE, FLUSH} state_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] head, tail;
  state_t        state, state_nx;
  logic [CW-1:0] count_nx;
  logic          store, read, empty, full, flushing, accept, coal, push, drop;

  always_comb begin
    store    = cpu_fb_en & cpu_mem_wen;
    read     = cpu_fb_en & ~cpu_mem_wen;
    empty    = (count == '0);
    full     = (count == FULL);
    flushing = (state == FLUSH);
    fb_wen   = ~empty & fb_grant;
    // flush_req wins over a same-cycle store, which stays held by the stall
    accept   = store & ~flushing & ~flush_req;
`ifdef FB_WRITE_COALESCE_EN
    // newest entry is only safe to patch if it is not leaving this cycle
    coal     = accept & ~empty & (mem[tail - PTR1].addr == cpu_addr) &
               ~((count == CNT1) & fb_wen);
`else
    coal     = 1'b0;
`endif
    push     = accept & ~coal & (~full | fb_wen);
    drop     = accept & ~coal & full & ~fb_wen;
    cpu_stall_req = (store & full & ~fb_wen & ~coal) | (read & ~empty) |
                    flushing | (store & flush_req);
    fb_addr  = empty ? '0 : mem[head].addr;
    fb_wdata = empty ? '0 : mem[head].data;
    unique case ({push, fb_wen})
      2'b10:   count_nx = count + CNT1;
      2'b01:   count_nx = count - CNT1;
      default: count_nx = count;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY, ACTIVE: begin
        if (flush_req)            state_nx = FLUSH;
        else if (count_nx != '0)  state_nx = ACTIVE;
        else                      state_nx = EMPTY;
      end
      FLUSH:   if (empty) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      state        <= EMPTY;
      flush_done   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (push)   tail <= tail + PTR1;
      if (fb_wen) head <= head + PTR1;
      count      <= count_nx;
      state      <= state_nx;
      flush_done <= flushing & empty;
      if (drop) overflow_err <= 1'b1;
    end
  end

  // storage needs no reset: pointers and count define what is valid
  always_ff @(posedge clock) begin
    if (push) mem[tail] <= '{addr: cpu_addr, data: cpu_wdata};
    if (coal) mem[tail - PTR1].data <= cpu_wdata;
  end
endmodule

// File: tb/tb_fb_write_buffer.sv
// Self-checking bench for fb_write_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fb_write_buffer;
  localparam int DEPTH = 8, ADDR_W = 16, DATA_W = 12;

  logic              clock = 1'b0;
  logic              reset, cpu_fb_en, cpu_mem_wen, flush_req, fb_grant;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall_req, flush_done, fb_wen, overflow_err;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_wdata;
  logic [3:0]        count;

  int n_checks = 0, n_fail = 0;

  fb_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .cpu_fb_en(cpu_fb_en), .cpu_mem_wen(cpu_mem_wen),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall_req(cpu_stall_req),
    .flush_req(flush_req), .flush_done(flush_done), .fb_grant(fb_grant),
    .fb_wen(fb_wen), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .count(count),
    .overflow_err(overflow_err));

  always #5 clock = ~clock;

  // reference model: a queue of pending writes plus flush/error flags
  typedef struct {logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} ent_t;
  ent_t q[$];
  bit   m_flush = 0, m_fdone = 0, m_ovf = 0;
  logic e_stall, e_wen, e_fdone, e_ovf, e_coal;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;
  logic [3:0] e_count;

  task automatic model_eval();
    bit st, rd;
    st = cpu_fb_en && cpu_mem_wen;
    rd = cpu_fb_en && !cpu_mem_wen;
    e_count = 4'(q.size());
    e_wen   = (q.size() != 0) && fb_grant;
    e_addr  = (q.size() != 0) ? q[0].a : '0;
    e_data  = (q.size() != 0) ? q[0].d : '0;
    e_coal  = 1'b0;
`ifdef FB_WRITE_COALESCE_EN
    if (st && !m_flush && !flush_req && q.size() != 0)
      e_coal = (q[q.size()-1].a == cpu_addr) && !(q.size() == 1 && e_wen);
`endif
    e_stall = (st && q.size() == DEPTH && !e_wen && !e_coal) || (rd && q.size() != 0) ||
              m_flush || (st && flush_req);
    e_fdone = m_fdone;
    e_ovf   = m_ovf;
  endtask

  task automatic model_step();
    int  sz;
    bit  nf, fd;
    model_eval();
    if (reset) begin
      q.delete(); m_flush = 0; m_fdone = 0; m_ovf = 0;
      return;
    end
    sz = q.size();
    fd = m_flush && sz == 0;
    nf = m_flush ? (sz != 0) : flush_req;
    if (e_coal) q[sz-1].d = cpu_wdata;
    if (e_wen) void'(q.pop_front());
    if (cpu_fb_en && cpu_mem_wen && !m_flush && !flush_req && !e_coal) begin
      if (sz < DEPTH || e_wen) q.push_back('{a: cpu_addr, d: cpu_wdata});
      else m_ovf = 1;
    end
    m_flush = nf;
    m_fdone = fd;
  endtask

  task automatic set_in(input logic en, input logic wen, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic g, input logic fl);
    cpu_fb_en = en; cpu_mem_wen = wen; cpu_addr = a; cpu_wdata = d;
    fb_grant = g; flush_req = fl;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic g);
    set_in(0, 0, '0, '0, g, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(0);
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    idle(1);
    n_checks++;
    if ({count, fb_wen, fb_addr, fb_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_fifo: got cnt=%0d wen=%b a=%h d=%h required all 0", count, fb_wen, fb_addr, fb_wdata);
    end
    n_checks++;
    if ({flush_done, overflow_err, cpu_stall_req} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got fd=%b ovf=%b stall=%b required 000", flush_done, overflow_err, cpu_stall_req);
    end
  endtask

  task automatic test_single_store();
    set_in(1, 1, 16'h0100, 12'hABC, 1, 0);
    n_checks++;
    if (cpu_stall_req !== 1'b0) begin n_fail++; $display("FAIL single_stall: got %b required 0", cpu_stall_req); end
    tick();
    idle(1);
    n_checks++;
    if ({fb_wen, fb_addr, fb_wdata, count} !== {1'b1, 16'h0100, 12'hABC, 4'd1}) begin
      n_fail++; $display("FAIL single_write: got wen=%b a=%h d=%h cnt=%0d required 1 0100 abc 1", fb_wen, fb_addr, fb_wdata, count);
    end
    tick();
    n_checks++;
    if ({fb_wen, count} !== 5'd0) begin n_fail++; $display("FAIL single_drain: got wen=%b cnt=%0d required 0 0", fb_wen, count); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, 1, 16'(i), 12'(i + 16), 0, 0);
      tick();
    end
    idle(0);
    n_checks++;
    if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count: got %0d required 8", count); end
    set_in(1, 1, 16'h0008, 12'h5A5, 0, 0);
    n_checks++;
    if (cpu_stall_req !== 1'b1) begin n_fail++; $display("FAIL fill_9th_stall: got %b required 1", cpu_stall_req); end
    set_in(1, 1, 16'h0008, 12'h5A5, 1, 0);
    n_checks++;
    if (cpu_stall_req !== 1'b0) begin n_fail++; $display("FAIL fill_9th_release: got %b required 0", cpu_stall_req); end
    for (int k = 0; k <= DEPTH; k++) begin
      n_checks++;
      if ({fb_wen, fb_addr} !== {1'b1, 16'(k)}) begin
        n_fail++; $display("FAIL wrap_order[%0d]: got wen=%b a=%h required 1 %h", k, fb_wen, fb_addr, 16'(k));
      end
      tick();
      idle(1);
    end
    n_checks++;
    if ({count, overflow_err} !== 5'd0) begin n_fail++; $display("FAIL wrap_end: got cnt=%0d ovf=%b required 0 0", count, overflow_err); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, 1, 16'(16 + i), 12'(i), 0, 0);
      tick();
    end
    set_in(1, 1, 16'h0200, 12'h222, 1, 0);
    n_checks++;
    if ({cpu_stall_req, fb_wen, fb_addr} !== {2'b01, 16'h0010}) begin
      n_fail++; $display("FAIL fullpop_accept: got stall=%b wen=%b a=%h required 0 1 0010", cpu_stall_req, fb_wen, fb_addr);
    end
    tick();
    idle(1);
    n_checks++;
    if ({count, fb_addr} !== {4'd8, 16'h0011}) begin
      n_fail++; $display("FAIL fullpop_head: got cnt=%0d a=%h required 8 0011", count, fb_addr);
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (k == DEPTH - 1) begin
        n_checks++;
        if (fb_addr !== 16'h0200) begin n_fail++; $display("FAIL fullpop_last: got %h required 0200", fb_addr); end
      end
      tick();
      idle(1);
    end
    n_checks++;
    if (count !== 4'd0) begin n_fail++; $display("FAIL fullpop_drain: got %0d required 0", count); end
  endtask

  task automatic test_read_hazard();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1, 16'(32 + i), 12'(i), 0, 0);
      tick();
    end
    set_in(1, 0, 16'h0020, '0, 0, 0);
    n_checks++;
    if (cpu_stall_req !== 1'b1) begin n_fail++; $display("FAIL raw_stall_nogrant: got %b required 1", cpu_stall_req); end
    tick();
    for (int k = 2; k >= 0; k--) begin
      set_in(1, 0, 16'h0020, '0, 1, 0);
      n_checks++;
      if ({count, cpu_stall_req} !== {4'(k), k != 0}) begin
        n_fail++; $display("FAIL raw_stall[%0d]: got cnt=%0d stall=%b required %0d %b", k, count, cpu_stall_req, k, k != 0);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    int zero_c = -1, done_c = -1, pulses = 0, maxc = 0;
    bit seen = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 16'(48 + i), 12'(i), 0, 0);
      tick();
    end
    set_in(1, 1, 16'h0777, 12'h777, 0, 1);
    n_checks++;
    if (cpu_stall_req !== 1'b1) begin n_fail++; $display("FAIL flush_req_stall: got %b required 1", cpu_stall_req); end
    tick();
    for (int c = 0; c < 20; c++) begin
      if (done_c < 0) set_in(1, 1, 16'h0777, 12'h777, c[0], 0);
      else idle(c[0]);
      if (count == 0 && zero_c < 0) zero_c = c;
      if (int'(count) > maxc) maxc = int'(count);
      if (flush_done) begin pulses++; done_c = c; end
      if (fb_wen && fb_addr == 16'h0777) seen = 1;
      tick();
    end
    n_checks++;
    if (pulses != 1 || done_c != zero_c + 1 || zero_c < 0) begin
      n_fail++; $display("FAIL flush_done: got pulses=%0d at %0d (zero at %0d) required 1 pulse one cycle after zero", pulses, done_c, zero_c);
    end
    n_checks++;
    if (maxc > 3) begin n_fail++; $display("FAIL flush_no_accept: got max count %0d required <=3", maxc); end
    n_checks++;
    if (!seen || count !== 4'd0) begin n_fail++; $display("FAIL flush_held_store: got written=%b cnt=%0d required 1 0", seen, count); end
  endtask

  task automatic test_overflow_and_reset_mid();
    for (int i = 0; i <= DEPTH; i++) begin
      set_in(1, 1, 16'(64 + i), 12'(i), 0, 0);
      tick();
    end
    idle(0);
    n_checks++;
    if ({overflow_err, count} !== {1'b1, 4'd8}) begin
      n_fail++; $display("FAIL overflow: got ovf=%b cnt=%0d required 1 8", overflow_err, count);
    end
    set_in(0, 0, '0, '0, 0, 1);
    tick();
    reset = 1'b1; idle(1); tick(); reset = 1'b0;
    idle(1);
    n_checks++;
    if ({overflow_err, count, fb_wen} !== 6'd0) begin
      n_fail++; $display("FAIL reset_mid: got ovf=%b cnt=%0d wen=%b required 0 0 0", overflow_err, count, fb_wen);
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_flush[%0d]: got %b required 0", c, flush_done); end
      tick();
    end
  endtask

  task automatic test_coalesce();
    set_in(1, 1, 16'h0300, 12'h111, 0, 0); tick();
    set_in(1, 1, 16'h0300, 12'h222, 0, 0);
    n_checks++;
    if (cpu_stall_req !== 1'b0) begin n_fail++; $display("FAIL coal_stall: got %b required 0", cpu_stall_req); end
    tick();
    idle(1);
`ifdef FB_WRITE_COALESCE_EN
    n_checks++;
    if ({count, fb_wdata} !== {4'd1, 12'h222}) begin
      n_fail++; $display("FAIL coal_merge: got cnt=%0d d=%h required 1 222", count, fb_wdata);
    end
    tick();
`else
    n_checks++;
    if ({count, fb_wdata} !== {4'd2, 12'h111}) begin
      n_fail++; $display("FAIL coal_first: got cnt=%0d d=%h required 2 111", count, fb_wdata);
    end
    tick();
    n_checks++;
    if (fb_wdata !== 12'h222) begin n_fail++; $display("FAIL coal_second: got %h required 222", fb_wdata); end
    tick();
`endif
    n_checks++;
    if (count !== 4'd0) begin n_fail++; $display("FAIL coal_drain: got %0d required 0", count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(199) == 0);
      set_in($urandom_range(3) != 0, $urandom_range(3) != 0, 16'($urandom_range(3)),
             12'($urandom), $urandom_range(2) == 0, $urandom_range(29) == 0);
      model_eval();
      n_checks++;
      if ({cpu_stall_req, fb_wen, fb_addr, fb_wdata, count, flush_done, overflow_err} !==
          {e_stall, e_wen, e_addr, e_data, e_count, e_fdone, e_ovf}) begin
        n_fail++;
        $display("FAIL random[%0d]: got stall=%b wen=%b a=%h d=%h cnt=%0d fd=%b ovf=%b required %b %b %h %h %0d %b %b",
                 c, cpu_stall_req, fb_wen, fb_addr, fb_wdata, count, flush_done, overflow_err,
                 e_stall, e_wen, e_addr, e_data, e_count, e_fdone, e_ovf);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle(0);
    test_reset();
    test_single_store();
    test_fill_wrap();
    test_full_pop();
    test_read_hazard();
    test_flush();
    test_overflow_and_reset_mid();
    test_coalesce();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_write_buffer.md
# fb_write_buffer

Posted-write buffer between the datapath's memory-stage frame-buffer port and the frame-buffer RAM write port. It captures CPU frame-buffer stores into a small FIFO and drains them only in cycles where the display controller grants write access, such as blanking, so scanout never collides with CPU stores. When the FIFO is full, when a frame-buffer read would bypass pending writes, or while a flush is in progress, it raises a stall request toward the hazard unit.

## Interface
- DEPTH, 8, number of FIFO entries; must be a power of two, ≥2.
- ADDR_W, 16, frame-buffer address width.
- DATA_W, 12, frame-buffer data width.

- clock  in  1  sole clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- cpu_fb_en  in  1  frame-buffer enable from the EX/MEM stage.
- cpu_mem_wen  in  1  write enable from EX/MEM; a store is cpu_fb_en & cpu_mem_wen, and a read is cpu_fb_en & !cpu_mem_wen.
- cpu_addr  in  ADDR_W  store or read address.
- cpu_wdata  in  DATA_W  store data.
- cpu_stall_req  out  1  stall request to the hazard unit (combinational).
- flush_req  in  1  single-cycle pulse: drain everything, then acknowledge.
- flush_done  out  1  one-cycle pulse when a flush completes.
- fb_grant  in  1  display controller permits a write this cycle.
- fb_wen  out  1  frame-buffer RAM write strobe.
- fb_addr  out  ADDR_W  write address (head entry).
- fb_wdata  out  DATA_W  write data (head entry).
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow_err  out  1  sticky error: a store was dropped.

## Operation
- Circular FIFO with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
- **Push:** a store pushes when state≠FLUSH and (count<DEPTH, or a pop occurs in the same cycle).
- **Pop:** fb_wen = (count≠0) & fb_grant. fb_addr and fb_wdata always show the head entry, or 0 when empty. The head is popped on every edge where fb_wen=1.
- **Simultaneous push and pop:** count is unchanged and both pointers advance. This applies even when the FIFO is full.
- **Dropped store:** a store arriving with count==DEPTH and no pop is dropped and overflow_err is set. This can only happen if the hazard unit ignores the stall. overflow_err clears only on reset.
- **Stores during FLUSH:** not pushed and not flagged; the stall holds them in EX/MEM.
- **cpu_stall_req** = (store & count==DEPTH & !fb_wen) | (read & count≠0) | (state==FLUSH). The read term preserves read-after-write ordering.
- **States:**
  - EMPTY: count==0.
  - ACTIVE: count>0.
  - FLUSH: draining on request.
- **Transitions:**
  - EMPTY→ACTIVE on a push.
  - ACTIVE→EMPTY when the last entry pops with no push.
  - EMPTY or ACTIVE→FLUSH on flush_req.
  - FLUSH→EMPTY on the edge after count reaches 0; flush_done pulses in that cycle.
  - flush_req while already in FLUSH is ignored.
  - flush_req while EMPTY still enters FLUSH, and flush_done pulses on the following cycle.
- **Priority:** reset beats flush_req, and flush_req beats a push in the same cycle, so that store is stalled rather than accepted.

## Timing
- A store accepted at edge N is visible on fb_wen/fb_addr/fb_wdata from cycle N+1 if it is the head and fb_grant=1. Minimum latency is 1 cycle.
- With continuous grant, sustained throughput is one write per cycle.
- cpu_stall_req and fb_wen are combinational from their inputs and registered state. All other state is registered.
- **Reset values:** count=0, pointers=0, state=EMPTY, fb_wen=0, fb_addr=0, fb_wdata=0, flush_done=0, overflow_err=0, cpu_stall_req=0 while inputs are idle.
- **Reset mid-operation:** buffered entries are discarded with no further fb_wen, and an in-progress flush is abandoned with no flush_done.

## Configuration
- **FB_WRITE_COALESCE_EN defined:** a store whose cpu_addr equals the tail-1 (newest) entry's address overwrites that entry's data in place. No push happens, count is unchanged, and no stall is raised for fullness.
  - Coalescing is suppressed when that entry is being popped in the same cycle, i.e. count==1 & fb_wen; the store then pushes normally.
- **FB_WRITE_COALESCE_EN undefined:** every accepted store allocates an entry.

## Test plan
- **Single store:** reset; store addr 0x0100 data 0xABC with fb_grant=1 → fb_wen=1, fb_addr=0x0100, fb_wdata=0xABC in the next cycle; count returns to 0.
- **Fill and wrap:** fb_grant=0; issue 8 stores to 0x0000–0x0007 → count=8; a 9th store raises cpu_stall_req=1. Then grant for 12 cycles → writes drain in order 0x0000…0x0007 and the held 9th store drains last, exercising pointer wrap; overflow_err stays 0.
- **Full with simultaneous pop:** count=8, fb_grant=1, store 0x0200 → accepted with no stall; count stays 8 and the head advances.
- **Read hazard:** 2 pending entries with fb_grant=0, then an fb read → cpu_stall_req=1 until count=0; it deasserts in the cycle after the last pop.
- **Flush:** 3 entries, pulse flush_req with fb_grant toggling 1/0 → no new stores accepted; flush_done pulses once, exactly one cycle after count hits 0.
- **Coalesce (macro defined):** with fb_grant=0, store 0x0300 data 0x111 then 0x0300 data 0x222 → count=1; on grant the single write carries 0x222. With the macro undefined → count=2, and the writes carry 0x111 then 0x222.
